line_doubler_scan: RTL and testbench
====================================

Name: line_doubler_scan

Overview:
- Parametrised successor to the passthrough Hq2x stub.
- Captures each input video line into a ping-pong line buffer and replays the previous complete line at the output pixel rate, twice per input line.
- Optional per-channel scanline darkening on odd output rows.
- Sits between the core video mux and the MiSTer/MC2 video output stage.

Parameters:
LENGTH, 512, max pixels stored per line; power of two, 64..1024
HALF_DEPTH, 0, 1 = 12-bit pixels (4 bits/channel), 0 = 24-bit pixels (8 bits/channel)
DWIDTH, HALF_DEPTH?11:23, pixel MSB index (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ce_in  in  1  input pixel strobe
inputpixel  in  DWIDTH+1  input pixel {R,G,B}, R in MSBs
mono  in  1  1 = replicate B channel into R and G at write time
mode  in  2  00 bypass, 01 double, 10 double + 50% scanline, 11 double + 25% scanline
reset_line  in  1  start of input line, qualified by ce_in
reset_frame  in  1  start of input frame, qualified by ce_in
ce_out  in  1  output pixel strobe
read_y  in  2  output row index within the doubled pair; bit0 = odd row
hblank  in  1  output horizontal blank
outpixel  out  DWIDTH+1  output pixel, registered

Behaviour:
- Reset (async assert, sync release): outpixel=0, wr_x=0, rd_x=0, wr_bank=0, line_valid=0.
- Storage: two banks of LENGTH x (DWIDTH+1), inferred dual-port RAM.
  - Write side uses wr_bank.
  - Read side uses ~wr_bank.
- Write side, on cycles with ce_in=1:
  - reset_frame=1: wr_x<=1, wr_bank<=0, line_valid<=0, pixel written to bank0[0].
  - Else reset_line=1:
    - wr_bank toggles.
    - line_valid<=1 if the old wr_x>0.
    - Pixel written to new bank at x=0; wr_x<=1.
  - Else, if wr_x<LENGTH: write at wr_x, wr_x<=wr_x+1.
  - Else (overflow): write dropped, wr_x holds at LENGTH.
  - reset_frame takes priority over reset_line in the same cycle.
  - reset_line/reset_frame with ce_in=0 are ignored.
- Mono: when mono=1, written word = {B,B,B}, where B is the low channel of inputpixel.
- Read side:
  - hblank=1 (any cycle): rd_x<=0.
  - ce_out=1 and hblank=0:
    - Read address rd_x; rd_x increments and saturates at LENGTH.
  - Reads at rd_x>=LENGTH, or while line_valid=0, yield 0 (black).
- Latency:
  - outpixel updates only on ce_out cycles.
  - Value reflects the address presented on the previous ce_out (2-stage: RAM read, then shade/register).
  - First ce_out after hblank falls therefore outputs the stale pipeline value; the second outputs pixel 0.
- Shading, applied per channel c with width W (4 or 8), on the odd row (read_y[0]=1) only:
  - mode 10: c>>1.
  - mode 11: c-(c>>2), truncating, no overflow possible.
  - mode 01, or read_y[0]=0: unmodified.
- Bypass (mode 00):
  - outpixel<=inputpixel (with mono replication) on every ce_in cycle.
  - RAM writes continue; read pipeline ignored.
- Mode changes take effect on the next ce_out (double modes) or next ce_in (bypass); no flush.
- reset_frame mid-line: current write line is abandoned and the read bank is marked invalid; output is black until the first reset_line following a non-empty line.
- read_y[1] is unused (reserved for 3x modes); it has no effect.

Test Plan:
- Reset: assert rst mid-frame -> outpixel=0, subsequent reads black until a full line is written and reset_line seen.
- Basic double:
  - Stimulus: mode=01, write line 0..7 with pixel=x*0x010101, pulse reset_line, then hblank low, 9 ce_out pulses with read_y=0 then read_y=1.
  - Response: outputs after one-strobe latency are 0x000000, 0x010101, ... 0x070707 on both rows.
- Scanlines:
  - Stored pixel 0xFF8040, read_y=1.
  - mode=10 -> 0x7F4020.
  - mode=11 -> 0xC06030.
  - read_y=0 -> 0xFF8040.
- Overflow: LENGTH=64, write 70 pixels -> wr_x saturates at 64; reads at rd_x 0..63 return the first 64 pixels, rd_x>=64 returns 0.
- Priority/mono:
  - reset_frame and reset_line in the same ce_in cycle -> wr_bank=0, line_valid=0.
  - mono=1 with input 0x00005A -> stored/output 0x5A5A5A.
- HALF_DEPTH=1, mode=10, stored 0xF84 on odd row -> 0x742; bypass mode -> outpixel follows inputpixel one clock after ce_in.

Source files
------------

// File: rtl/line_doubler_scan.sv
// Line doubler with ping-pong line buffer: each captured input line is replayed
// twice at the output pixel rate, with optional darkening of odd output rows.
module line_doubler_scan #(
    parameter int LENGTH     = 512,
    parameter int HALF_DEPTH = 0,
    localparam int DWIDTH    = (HALF_DEPTH != 0) ? 11 : 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce_in,
    input  logic [DWIDTH:0] inputpixel,
    input  logic            mono,
    input  logic [1:0]      mode,
    input  logic            reset_line,
    input  logic            reset_frame,
    input  logic            ce_out,
    input  logic [1:0]      read_y,
    input  logic            hblank,
    output logic [DWIDTH:0] outpixel
);
    localparam int CW = (DWIDTH + 1) / 3;
    localparam int AW = $clog2(LENGTH);
    localparam int XW = AW + 1;
    localparam logic [XW-1:0] LEN_X = XW'(LENGTH);

    logic [DWIDTH:0] mem [0:2*LENGTH-1];

    logic [XW-1:0]   wr_x_q, wr_x_d;
    logic            wr_bank_q, wr_bank_d;
    logic            line_valid_q, line_valid_d;
    logic [XW-1:0]   rd_x_q, rd_x_d;
    logic [DWIDTH:0] rd_pix_p1_q;
    logic [DWIDTH:0] outpixel_q;

    logic            wr_en;
    logic [AW:0]     wr_addr;
    logic [DWIDTH:0] wr_pix;
    logic            rd_adv;
    logic            rd_ok;
    logic            unused_read_y;

    assign unused_read_y = read_y[1];

    function automatic logic [DWIDTH:0] shade(input logic [DWIDTH:0] p,
                                              input logic [1:0]      m,
                                              input logic            odd);
        logic [CW-1:0] c;
        shade = p;
        if (odd && m[1]) begin
            for (int i = 0; i < 3; i++) begin
                c = p[i*CW +: CW];
                shade[i*CW +: CW] = m[0] ? (c - (c >> 2)) : (c >> 1);
            end
        end
    endfunction

    // Write side: line/frame bookkeeping and RAM write port
    always_comb begin
        wr_pix       = mono ? {3{inputpixel[CW-1:0]}} : inputpixel;
        wr_x_d       = wr_x_q;
        wr_bank_d    = wr_bank_q;
        line_valid_d = line_valid_q;
        wr_en        = 1'b0;
        wr_addr      = {wr_bank_q, wr_x_q[AW-1:0]};
        if (ce_in) begin
            if (reset_frame) begin
                wr_x_d       = XW'(1);
                wr_bank_d    = 1'b0;
                line_valid_d = 1'b0;
                wr_en        = 1'b1;
                wr_addr      = '0;
            end else if (reset_line) begin
                wr_x_d       = XW'(1);
                wr_bank_d    = ~wr_bank_q;
                line_valid_d = (wr_x_q != '0);
                wr_en        = 1'b1;
                wr_addr      = {~wr_bank_q, {AW{1'b0}}};
            end else if (wr_x_q < LEN_X) begin
                wr_x_d = wr_x_q + XW'(1);
                wr_en  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_x_q       <= '0;
            wr_bank_q    <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            wr_x_q       <= wr_x_d;
            wr_bank_q    <= wr_bank_d;
            line_valid_q <= line_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_pix;
    end

    // Read side: pixel counter restarts every blank and saturates past the line end
    assign rd_adv = ce_out && !hblank;
    assign rd_ok  = line_valid_q && (rd_x_q < LEN_X);

    always_comb begin
        rd_x_d = rd_x_q;
        if (hblank) begin
            rd_x_d = '0;
        end else if (ce_out && (rd_x_q < LEN_X)) begin
            rd_x_d = rd_x_q + XW'(1);
        end
    end

    // Stage p1: RAM read from the bank not being written, blanked when invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_x_q      <= '0;
            rd_pix_p1_q <= '0;
        end else begin
            rd_x_q <= rd_x_d;
            if (rd_adv) begin
                rd_pix_p1_q <= rd_ok ? mem[{~wr_bank_q, rd_x_q[AW-1:0]}] : '0;
            end
        end
    end

    // Stage p2: shading and output register; bypass follows the input strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outpixel_q <= '0;
        end else if (mode == 2'b00) begin
            if (ce_in) outpixel_q <= wr_pix;
        end else if (rd_adv) begin
            outpixel_q <= shade(rd_pix_p1_q, mode, read_y[0]);
        end
    end

    assign outpixel = outpixel_q;

endmodule

// File: tb/tb_line_doubler_scan.sv
// Directed bench for line_doubler_scan: a 24-bit instance checked every cycle
// against a line-buffer model, plus a 12-bit instance with literal expectations.
module tb_line_doubler_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce_in, reset_line, reset_frame, ce_out, hblank, mono;
    logic [1:0]  mode, read_y;
    logic [23:0] inputpixel, outpixel_a;

    logic        b_ce_in, b_rl, b_rf, b_co, b_hb, b_mn;
    logic [1:0]  b_md, b_ry;
    logic [11:0] b_pix, outpixel_b;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    // model state
    logic [23:0] bankm [0:1][0:63];
    int          wx, rx;
    bit          wb, lv;
    logic [23:0] s1m, outm;

    always #5 clk = ~clk;

    line_doubler_scan #(.LENGTH(64), .HALF_DEPTH(0)) dut_a (
        .clk(clk), .rst(rst), .ce_in(ce_in), .inputpixel(inputpixel), .mono(mono),
        .mode(mode), .reset_line(reset_line), .reset_frame(reset_frame),
        .ce_out(ce_out), .read_y(read_y), .hblank(hblank), .outpixel(outpixel_a)
    );

    line_doubler_scan #(.LENGTH(64), .HALF_DEPTH(1)) dut_b (
        .clk(clk), .rst(rst), .ce_in(b_ce_in), .inputpixel(b_pix), .mono(b_mn),
        .mode(b_md), .reset_line(b_rl), .reset_frame(b_rf),
        .ce_out(b_co), .read_y(b_ry), .hblank(b_hb), .outpixel(outpixel_b)
    );

    function automatic logic [23:0] shade_m(input logic [23:0] p, input logic [1:0] m,
                                            input logic odd);
        logic [23:0] r;
        int c;
        r = p;
        if (odd && (m == 2'b10 || m == 2'b11)) begin
            for (int i = 0; i < 3; i++) begin
                c = int'(p[8*i +: 8]);
                r[8*i +: 8] = (m == 2'b10) ? 8'(c / 2) : 8'(c - c / 4);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock of A stimulus; the model applies the behavioural rules to it.
    task automatic cyc(input logic ci, input logic [23:0] pix, input logic rl,
                       input logic rf, input logic co, input logic hb,
                       input logic [1:0] ry);
        logic [23:0] wp, o_n, s1_n;
        int rx_n;
        ce_in = ci; inputpixel = pix; reset_line = rl; reset_frame = rf;
        ce_out = co; hblank = hb; read_y = ry;
        wp   = mono ? {3{pix[7:0]}} : pix;
        o_n  = outm;
        s1_n = s1m;
        if (mode == 2'b00) begin
            if (ci) o_n = wp;
        end else if (co && !hb) begin
            o_n = shade_m(s1m, mode, ry[0]);
        end
        if (co && !hb) s1_n = (lv && rx < 64) ? bankm[wb ? 0 : 1][rx] : 24'h0;
        rx_n = hb ? 0 : ((co && rx < 64) ? rx + 1 : rx);
        if (ci) begin
            if (rf) begin
                bankm[0][0] = wp; wx = 1; wb = 1'b0; lv = 1'b0;
            end else if (rl) begin
                lv = (wx > 0); wb = !wb; bankm[wb ? 1 : 0][0] = wp; wx = 1;
            end else if (wx < 64) begin
                bankm[wb ? 1 : 0][wx] = wp; wx++;
            end
        end
        @(posedge clk);
        #1;
        outm = o_n; s1m = s1_n; rx = rx_n;
    endtask

    task automatic idle();
        cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    endtask

    task automatic pulse(input logic [1:0] ry);
        cyc(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0, ry);
    endtask

    task automatic read2(input logic [1:0] ry);
        idle();
        pulse(ry);
        pulse(ry);
    endtask

    task automatic model_reset();
        wx = 0; rx = 0; wb = 1'b0; lv = 1'b0; s1m = 24'h0; outm = 24'h0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            checks++;
            if (outpixel_a !== outm) begin
                errors++;
                $display("FAIL model_cmp at %0t: got %h, want %h", $time, outpixel_a, outm);
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 2'b01; mono = 1'b0;
        ce_in = 0; reset_line = 0; reset_frame = 0; ce_out = 0; hblank = 1; read_y = 0;
        inputpixel = 0;
        b_ce_in = 0; b_rl = 0; b_rf = 0; b_co = 0; b_hb = 1; b_mn = 0; b_md = 2'b10;
        b_ry = 0; b_pix = 0;
        model_reset();
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", outpixel_a, 24'h0);
        rst = 1'b0;

        // fill both banks so every location holds a known value
        cyc(1, 24'hA00000, 0, 1, 0, 1, 0);
        for (int x = 1; x < 64; x++) cyc(1, 24'hA00000 | 24'(x), 0, 0, 0, 1, 0);
        cyc(1, 24'hB00000, 1, 0, 0, 1, 0);
        for (int x = 1; x < 64; x++) cyc(1, 24'hB00000 | 24'(x), 0, 0, 0, 1, 0);

        // basic double
        for (int x = 0; x < 8; x++) cyc(1, 24'(x) * 24'h010101, (x == 0), 0, 0, 1, 0);
        cyc(1, 24'hEEEEEE, 1, 0, 0, 1, 0);
        for (int row = 0; row < 2; row++) begin
            idle();
            for (int k = 1; k <= 9; k++) begin
                pulse(2'(row));
                if (k >= 2) chk(row == 0 ? "dbl_row0" : "dbl_row1", outpixel_a,
                                24'(k - 2) * 24'h010101);
            end
        end

        // scanlines
        cyc(1, 24'hFF8040, 1, 0, 0, 1, 0);
        cyc(1, 24'h000000, 1, 0, 0, 1, 0);
        mode = 2'b10; read2(2'b01); chk("scan50", outpixel_a, 24'h7F4020);
        mode = 2'b11; read2(2'b01); chk("scan25", outpixel_a, 24'hC06030);
        read2(2'b00); chk("scan_even", outpixel_a, 24'hFF8040);
        read2(2'b10); chk("scan_y1_ignored", outpixel_a, 24'hFF8040);
        read2(2'b11); chk("scan25_y3", outpixel_a, 24'hC06030);
        mode = 2'b01; read2(2'b01); chk("double_odd", outpixel_a, 24'hFF8040);

        // overflow: 70 writes into a 64-pixel line
        for (int x = 0; x < 70; x++) cyc(1, {8'h30, 8'(x), 8'h0F}, (x == 0), 0, 0, 1, 0);
        cyc(1, 24'h123456, 1, 0, 0, 1, 0);
        idle();
        for (int k = 1; k <= 67; k++) begin
            pulse(2'b00);
            if (k == 2)  chk("ovf_first", outpixel_a, 24'h30000F);
            if (k == 65) chk("ovf_last", outpixel_a, 24'h303F0F);
            if (k >= 66) chk("ovf_black", outpixel_a, 24'h0);
        end

        // priority of reset_frame, ignored strobes without ce_in
        cyc(1, 24'h111111, 1, 1, 0, 1, 0);
        read2(2'b00); chk("prio_black", outpixel_a, 24'h0);
        cyc(1, 24'h222222, 0, 0, 0, 1, 0);
        cyc(1, 24'h333333, 1, 0, 0, 1, 0);
        read2(2'b00); chk("prio_line", outpixel_a, 24'h111111);
        cyc(0, 24'h444444, 1, 0, 0, 1, 0);
        cyc(0, 24'h555555, 0, 1, 0, 1, 0);
        read2(2'b00); chk("no_ce_ignored", outpixel_a, 24'h111111);

        // mono replication
        mono = 1'b1;
        cyc(1, 24'h00005A, 1, 0, 0, 1, 0);
        cyc(1, 24'h000000, 1, 0, 0, 1, 0);
        mono = 1'b0;
        read2(2'b00); chk("mono_double", outpixel_a, 24'h5A5A5A);

        // bypass
        mode = 2'b00;
        cyc(1, 24'hC0FFEE, 0, 0, 0, 1, 0); chk("bypass", outpixel_a, 24'hC0FFEE);
        mono = 1'b1;
        cyc(1, 24'h12345A, 0, 0, 0, 1, 0); chk("bypass_mono", outpixel_a, 24'h5A5A5A);
        mono = 1'b0;
        cyc(0, 24'h999999, 0, 0, 1, 0, 0); chk("bypass_hold", outpixel_a, 24'h5A5A5A);

        // reset mid-frame
        mode = 2'b01;
        cyc(1, 24'hABCDEF, 1, 0, 0, 1, 0);
        cyc(1, 24'hFEDCBA, 0, 0, 0, 1, 0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("midreset_out", outpixel_a, 24'h0);
        rst = 1'b0;
        idle(); pulse(0); pulse(0); pulse(0); chk("post_reset_black", outpixel_a, 24'h0);
        cyc(1, 24'h777777, 1, 0, 0, 1, 0);
        read2(2'b00); chk("empty_line_black", outpixel_a, 24'h0);
        cyc(1, 24'h888888, 1, 0, 0, 1, 0);
        read2(2'b00); chk("post_reset_line", outpixel_a, 24'h777777);

        // 12-bit instance
        b_md = 2'b10;
        b_ce_in = 1; b_rf = 1; b_pix = 12'hF84; idle();
        b_rf = 0; b_rl = 1; b_pix = 12'h000; idle();
        b_ce_in = 0; b_rl = 0; b_hb = 1; idle();
        b_hb = 0; b_co = 1; b_ry = 2'b01; idle();
        chk("b_stale", 24'(outpixel_b), 24'h0);
        idle();
        chk("b_scan50", 24'(outpixel_b), 24'h742);
        b_co = 0; b_md = 2'b11; b_hb = 1; idle();
        b_hb = 0; b_co = 1; idle(); idle();
        chk("b_scan25", 24'(outpixel_b), 24'hC63);
        b_co = 0; b_md = 2'b00; b_ce_in = 1; b_pix = 12'hABC; idle();
        chk("b_bypass", 24'(outpixel_b), 24'hABC);
        b_ce_in = 0; b_pix = 12'h123; idle();
        chk("b_bypass_hold", 24'(outpixel_b), 24'hABC);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
